// File: rtl/gpio_in_conditioner.sv
// GPIO input conditioner: brings asynchronous board inputs into the clk
// domain, debounces them on a prescaled sample tick, and reports accepted
// edges as one-cycle pulses plus a sticky status register that software clears.

// One input bit: debounce counter, accepted level, edge pulses and sticky status.
module gpio_in_lane #(
  parameter int STABLE_COUNT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic sync_in,
  input  logic clr,
  output logic level,
  output logic rise,
  output logic fall,
  output logic status
);
  localparam int CW = $clog2(STABLE_COUNT + 1);
  // Count value at which one more differing sample accepts the new level.
  localparam logic [CW-1:0] LAST = CW'(STABLE_COUNT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic          status_q, status_d;

  // Debounce decision on each tick; pulses are computed here so they
  // register on the same edge as the level change.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (tick) begin
      if (sync_in == level_q) begin
        cnt_d = '0;
      end else if (cnt_q != LAST) begin
        cnt_d = cnt_q + CW'(1);
      end else begin
        cnt_d   = '0;
        level_d = sync_in;
        rise_d  = sync_in;
        fall_d  = ~sync_in;
      end
    end
    // A new edge overrides a simultaneous software clear.
    status_d = (status_q & ~clr) | rise_d | fall_d;
  end

  // Lane state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      level_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      status_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      status_q <= status_d;
    end
  end

  assign level  = level_q;
  assign rise   = rise_q;
  assign fall   = fall_q;
  assign status = status_q;
endmodule

module gpio_in_conditioner #(
  parameter int WIDTH        = 8,
  parameter int PRESCALE     = 1,
  parameter int STABLE_COUNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pins_async,
  input  logic [WIDTH-1:0] clr_status,
  output logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic [WIDTH-1:0] edge_status
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             tick;

  // Two-flop synchroniser and free-running prescaler; tick on the last count.
  always_comb begin
    sync1_d = pins_async;
    sync2_d = sync1_q;
    tick    = (pre_q == PRE_LAST);
    pre_d   = tick ? '0 : pre_q + PW'(1);
  end

  // Synchroniser and prescaler registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      pre_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      pre_q   <= pre_d;
    end
  end

  // Bits are fully independent: one lane instance per input.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    gpio_in_lane #(.STABLE_COUNT(STABLE_COUNT)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick),
      .sync_in (sync2_q[i]),
      .clr     (clr_status[i]),
      .level   (gpio_in[i]),
      .rise    (rise_pulse[i]),
      .fall    (fall_pulse[i]),
      .status  (edge_status[i])
    );
  end
endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Bench for gpio_in_conditioner: two configurations (PRESCALE=1/STABLE=4 and
// PRESCALE=3/STABLE=2) share pins and clears; a sample-history reference model
// pushes expected outputs per edge into a scoreboard, and a monitor compares.
module tb_gpio_in_conditioner;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [W-1:0] pins = '0;
  logic [W-1:0] clr = '0;
  logic [W-1:0] gi_a, rp_a, fp_a, es_a;
  logic [W-1:0] gi_b, rp_b, fp_b, es_b;

  always #5 clk = ~clk;

  gpio_in_conditioner #(.WIDTH(W), .PRESCALE(1), .STABLE_COUNT(4)) dut_a (
    .clk(clk), .rst(rst), .pins_async(pins), .clr_status(clr),
    .gpio_in(gi_a), .rise_pulse(rp_a), .fall_pulse(fp_a), .edge_status(es_a));

  gpio_in_conditioner #(.WIDTH(W), .PRESCALE(3), .STABLE_COUNT(2)) dut_b (
    .clk(clk), .rst(rst), .pins_async(pins), .clr_status(clr),
    .gpio_in(gi_b), .rise_pulse(rp_b), .fall_pulse(fp_b), .edge_status(es_b));

  typedef struct packed {
    logic [W-1:0] gi, rp, fp, es;
  } out_t;
  typedef struct packed {
    out_t a, b;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_pass = 0;

  // Reference model state: configuration, synchroniser delay, accepted level,
  // sticky status, and the tick samples seen since the last acceptance.
  int           cfg_p[2] = '{1, 3};
  int           cfg_s[2] = '{4, 2};
  logic [W-1:0] m_s1 = '0, m_s2 = '0;
  logic [W-1:0] m_lvl[2];
  logic [W-1:0] m_es[2];
  int           e_idx = 0;
  bit           hist[2][W][$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Predict the outputs after the coming edge from the current inputs.
  task automatic model_edge();
    exp_t e;
    out_t o[2];
    logic [W-1:0] seen;
    seen = m_s2;
    for (int d = 0; d < 2; d++) begin
      o[d] = '0;
      if (rst) begin
        m_lvl[d] = '0;
        m_es[d]  = '0;
        for (int b = 0; b < W; b++) hist[d][b].delete();
      end else begin
        if ((e_idx % cfg_p[d]) == cfg_p[d] - 1) begin
          for (int b = 0; b < W; b++) begin
            bit all_diff;
            hist[d][b].push_back(seen[b]);
            if (hist[d][b].size() > cfg_s[d]) void'(hist[d][b].pop_front());
            all_diff = (hist[d][b].size() == cfg_s[d]);
            for (int j = 0; j < hist[d][b].size(); j++)
              if (hist[d][b][j] == m_lvl[d][b]) all_diff = 0;
            if (all_diff) begin
              m_lvl[d][b] = seen[b];
              if (seen[b]) o[d].rp[b] = 1'b1;
              else         o[d].fp[b] = 1'b1;
              hist[d][b].delete();
            end
          end
        end
        m_es[d] = (m_es[d] & ~clr) | o[d].rp | o[d].fp;
      end
      o[d].gi = m_lvl[d];
      o[d].es = m_es[d];
    end
    if (rst) begin
      m_s1  = '0;
      m_s2  = '0;
      e_idx = 0;
    end else begin
      m_s2  = m_s1;
      m_s1  = pins;
      e_idx = e_idx + 1;
    end
    e.a = o[0];
    e.b = o[1];
    sb.push_back(e);
  endtask

  // Drive one cycle of inputs, model it, and return once its edge has been checked.
  task automatic step(input logic r, input logic [W-1:0] p, input logic [W-1:0] c);
    logic was;
    @(negedge clk);
    was  = rst;
    rst  = r;
    pins = p;
    clr  = c;
    if (r && !was) begin
      #1;
      chk("rst_async_gpio_in_a", gi_a, '0);
      chk("rst_async_rise_a", rp_a, '0);
      chk("rst_async_fall_a", fp_a, '0);
      chk("rst_async_status_a", es_a, '0);
      chk("rst_async_gpio_in_b", gi_b, '0);
      chk("rst_async_status_b", es_b, '0);
    end
    model_edge();
    @(posedge clk);
    #2;
  endtask

  // Monitor: every edge that has a prediction is compared against both DUTs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("a_gpio_in", gi_a, e.a.gi);
        chk("a_rise", rp_a, e.a.rp);
        chk("a_fall", fp_a, e.a.fp);
        chk("a_status", es_a, e.a.es);
        chk("b_gpio_in", gi_b, e.b.gi);
        chk("b_rise", rp_b, e.b.rp);
        chk("b_fall", fp_b, e.b.fp);
        chk("b_status", es_b, e.b.es);
      end
    end
  end

  initial begin
    logic [W-1:0] p;
    int rises;
    m_lvl = '{'0, '0};
    m_es  = '{'0, '0};
    step(1'b1, 8'h00, 8'h00);
    step(1'b1, 8'h00, 8'h00);

    // All pins high before edge 0: A accepts at edge 5, B at edge 5 (ticks 2 and 5).
    for (int k = 0; k < 5; k++) step(1'b0, 8'hFF, 8'h00);
    chk("t1_gpio_in_edge4", gi_a, 8'h00);
    step(1'b0, 8'hFF, 8'h00);
    chk("t1_gpio_in_edge5", gi_a, 8'hFF);
    chk("t1_rise_edge5", rp_a, 8'hFF);
    chk("t1_status_edge5", es_a, 8'hFF);
    chk("t5_b_gpio_in_edge5", gi_b, 8'hFF);
    step(1'b0, 8'hFF, 8'h00);
    chk("t1_rise_one_cycle", rp_a, 8'h00);

    // Return low and clear status, then a 3-clock glitch on bit 0.
    for (int k = 0; k < 10; k++) step(1'b0, 8'h00, 8'h00);
    step(1'b0, 8'h00, 8'hFF);
    chk("t4_clear_all", es_a, 8'h00);
    for (int k = 0; k < 3; k++) step(1'b0, 8'h01, 8'h00);
    for (int k = 0; k < 8; k++) step(1'b0, 8'h00, 8'h00);
    chk("t2_glitch_level", gi_a, 8'h00);
    chk("t2_glitch_status", es_a, 8'h00);

    // Bounce on bit 1: one rise, five edges after the final 0->1.
    rises = 0;
    step(1'b0, 8'h02, 8'h00); rises += int'(rp_a[1]);
    step(1'b0, 8'h00, 8'h00); rises += int'(rp_a[1]);
    step(1'b0, 8'h02, 8'h00); rises += int'(rp_a[1]);
    step(1'b0, 8'h00, 8'h00); rises += int'(rp_a[1]);
    step(1'b0, 8'h02, 8'h00); rises += int'(rp_a[1]);
    for (int k = 1; k <= 6; k++) begin
      step(1'b0, 8'h02, 8'h00);
      rises += int'(rp_a[1]);
      if (k == 4) chk("t3_no_rise_edge4", {7'b0, rp_a[1]}, 8'h00);
      if (k == 5) chk("t3_rise_edge5", {7'b0, rp_a[1]}, 8'h01);
    end
    chk("t3_single_rise", 8'(rises), 8'h01);

    // Bit 0 high and settled, status cleared, then fall with a same-cycle clear.
    for (int k = 0; k < 8; k++) step(1'b0, 8'h03, 8'h00);
    step(1'b0, 8'h03, 8'hFF);
    for (int k = 0; k < 5; k++) step(1'b0, 8'h02, 8'h00);
    step(1'b0, 8'h02, 8'h01);
    chk("t4_fall_pulse", fp_a, 8'h01);
    chk("t4_set_beats_clear", es_a, 8'h01);
    step(1'b0, 8'h02, 8'h01);
    chk("t4_later_clear", es_a, 8'h00);

    // Reset with bit 2 three samples into its debounce, then full latency again.
    for (int k = 0; k < 8; k++) step(1'b0, 8'h00, 8'hFF);
    for (int k = 0; k < 5; k++) step(1'b0, 8'h04, 8'h00);
    step(1'b1, 8'h04, 8'h00);
    step(1'b1, 8'h04, 8'h00);
    for (int k = 0; k < 5; k++) step(1'b0, 8'h04, 8'h00);
    chk("t6_gpio_in_edge4", gi_a, 8'h00);
    chk("t6_no_pulse", rp_a | fp_a, 8'h00);
    chk("t5_b_gpio_in_edge4", gi_b, 8'h00);
    step(1'b0, 8'h04, 8'h00);
    chk("t6_gpio_in_edge5", gi_a, 8'h04);
    chk("t5_b_gpio_in_edge5_again", gi_b, 8'h04);

    // Random pins with occasional holds and sparse clears.
    p = 8'h04;
    for (int k = 0; k < 600; k++) begin
      logic [W-1:0] c;
      if ($urandom_range(0, 3) == 0) p = p ^ 8'($urandom & $urandom);
      c = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
      step(($urandom_range(0, 299) == 0), p, c);
    end
    step(1'b0, p, 8'h00);

    chk("scoreboard_drained", 8'(sb.size()), 8'h00);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
